// File: rtl/dc_coeff_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dc_coeff_decoder                                              |
// | Brief    : Decodes one Huffman-coded DC coefficient (category code plus  |
// |            magnitude bits). Define DC_PRED_EN to add the DPCM predictor. |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module dc_coeff_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pred_clear,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [15:0] bit_series,
  output logic [4:0]  length,
  input  logic [3:0]  r_value,
  input  logic        is_valid,
  output logic [11:0] dc_value,
  output logic        dc_valid,
  input  logic        dc_ready,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CODE = 3'd1,
    MAG  = 3'd2,
    OUT  = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [3:0] c_max_code_len = 4'd9;

  state_t      r_state,    w_state_nxt;
  logic [15:0] r_code,     w_code_nxt;
  logic [3:0]  r_len,      w_len_nxt;
  logic [3:0]  r_rval,     w_rval_nxt;
  logic [15:0] r_mag,      w_mag_nxt;
  logic [3:0]  r_mcnt,     w_mcnt_nxt;
  logic [11:0] r_dc_value, w_dc_value_nxt;
  logic        r_dc_valid, w_dc_valid_nxt;
  logic        r_err,      w_err_nxt;

  logic        w_accept;
  logic [3:0]  w_len_inc;
  logic [3:0]  w_mcnt_inc;
  logic [15:0] w_mag_shift;
  logic        w_first;
  logic [11:0] w_mask;
  logic [11:0] w_diff;
  logic [11:0] w_pred;

  assign bit_ready = (r_state == CODE) || (r_state == MAG);
  assign w_accept  = bit_valid && bit_ready;

  // Candidate code: bits gathered so far plus the bit currently on the wire.
  assign bit_series = (r_state == CODE) ? (r_code | ({15'd0, bit_in} << r_len)) : 16'd0;
  assign length     = (r_state == CODE) ? ({1'b0, r_len} + 5'd1) : 5'd0;

  assign w_len_inc   = r_len + 4'd1;
  assign w_mcnt_inc  = r_mcnt + 4'd1;
  assign w_mag_shift = {r_mag[14:0], bit_in};

  // A leading 0 marks a negative difference: diff = m - (2^r - 1), taken mod 2^12.
  assign w_first = w_mag_shift[r_rval - 4'd1];
  assign w_mask  = (12'd1 << r_rval) - 12'd1;
  assign w_diff  = w_first ? w_mag_shift[11:0] : (w_mag_shift[11:0] - w_mask);

`ifdef DC_PRED_EN
  logic [11:0] r_pred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred <= 12'd0;
    end else if (pred_clear) begin
      r_pred <= 12'd0;
    end else if ((r_state == OUT) && dc_ready) begin
      r_pred <= r_dc_value;
    end
  end

  assign w_pred = r_pred;
`else
  logic w_unused_pred_clear;
  assign w_unused_pred_clear = pred_clear;
  assign w_pred = 12'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_code     <= 16'd0;
      r_len      <= 4'd0;
      r_rval     <= 4'd0;
      r_mag      <= 16'd0;
      r_mcnt     <= 4'd0;
      r_dc_value <= 12'd0;
      r_dc_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_len      <= w_len_nxt;
      r_rval     <= w_rval_nxt;
      r_mag      <= w_mag_nxt;
      r_mcnt     <= w_mcnt_nxt;
      r_dc_value <= w_dc_value_nxt;
      r_dc_valid <= w_dc_valid_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_code_nxt     = r_code;
    w_len_nxt      = r_len;
    w_rval_nxt     = r_rval;
    w_mag_nxt      = r_mag;
    w_mcnt_nxt     = r_mcnt;
    w_dc_value_nxt = r_dc_value;
    w_dc_valid_nxt = r_dc_valid;
    w_err_nxt      = r_err;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CODE;
          w_code_nxt  = 16'd0;
          w_len_nxt   = 4'd0;
        end
      end

      CODE: begin
        if (w_accept) begin
          if (is_valid) begin
            if (r_value == 4'd0) begin
              w_dc_value_nxt = w_pred;
              w_dc_valid_nxt = 1'b1;
              w_state_nxt    = OUT;
            end else begin
              w_rval_nxt  = r_value;
              w_mag_nxt   = 16'd0;
              w_mcnt_nxt  = 4'd0;
              w_state_nxt = MAG;
            end
          end else begin
            w_code_nxt = bit_series;
            w_len_nxt  = w_len_inc;
            if (w_len_inc == c_max_code_len) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ERR;
            end
          end
        end
      end

      MAG: begin
        if (w_accept) begin
          w_mag_nxt  = w_mag_shift;
          w_mcnt_nxt = w_mcnt_inc;
          if (w_mcnt_inc == r_rval) begin
            w_dc_value_nxt = w_diff + w_pred;
            w_dc_valid_nxt = 1'b1;
            w_state_nxt    = OUT;
          end
        end
      end

      OUT: begin
        if (dc_ready) begin
          w_dc_valid_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end
      end

      ERR: begin
        if (start) begin
          w_err_nxt   = 1'b0;
          w_code_nxt  = 16'd0;
          w_len_nxt   = 4'd0;
          w_state_nxt = CODE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign dc_value = r_dc_value;
  assign dc_valid = r_dc_valid;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dc_coeff_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dc_coeff_decoder                                           |
// | Brief    : Self-checking bench for dc_coeff_decoder with a JPEG DC table |
// |            model and an arithmetic DPCM reference (honours DC_PRED_EN).  |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tb_dc_coeff_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        pred_clear;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic [15:0] bit_series;
  logic [4:0]  length;
  logic [3:0]  r_value;
  logic        is_valid;
  logic [11:0] dc_value;
  logic        dc_valid;
  logic        dc_ready;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;
  int model_pred = 0;

  int t_cval;
  int t_clen;
  int t_seq;

  always #5 clk = ~clk;

  dc_coeff_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pred_clear (pred_clear),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .bit_series (bit_series),
    .length     (length),
    .r_value    (r_value),
    .is_valid   (is_valid),
    .dc_value   (dc_value),
    .dc_valid   (dc_valid),
    .dc_ready   (dc_ready),
    .err        (err)
  );

  // Standard JPEG luminance DC code for each category.
  function automatic void huff_code(input int cat, output int code, output int len);
    case (cat)
      0:       begin code = 'b00;        len = 2; end
      1:       begin code = 'b010;       len = 3; end
      2:       begin code = 'b011;       len = 3; end
      3:       begin code = 'b100;       len = 3; end
      4:       begin code = 'b101;       len = 3; end
      5:       begin code = 'b110;       len = 3; end
      6:       begin code = 'b1110;      len = 4; end
      7:       begin code = 'b11110;     len = 5; end
      8:       begin code = 'b111110;    len = 6; end
      9:       begin code = 'b1111110;   len = 7; end
      10:      begin code = 'b11111110;  len = 8; end
      default: begin code = 'b111111110; len = 9; end
    endcase
  endfunction

  always_comb begin
    is_valid = 1'b0;
    r_value  = 4'd0;
    t_seq    = 0;
    t_cval   = 0;
    t_clen   = 0;
    for (int i = 0; i < 16; i++)
      if (i < int'(length)) t_seq = (t_seq << 1) | int'(bit_series[i]);
    for (int k = 0; k < 12; k++) begin
      huff_code(k, t_cval, t_clen);
      if (length != 5'd0 && t_clen == int'(length) && t_cval == t_seq) begin
        is_valid = 1'b1;
        r_value  = 4'(k);
      end
    end
  end

  function automatic int model_diff(input int r, input int m);
    if (r == 0) return 0;
    if (((m >> (r - 1)) & 1) == 1) return m;
    return m - ((1 << r) - 1);
  endfunction

  function automatic logic [11:0] model_dc(input int diff);
    logic [31:0] sum;
`ifdef DC_PRED_EN
    sum = 32'(model_pred + diff);
`else
    sum = 32'(diff);
`endif
    return sum[11:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int exp_len, input logic [15:0] exp_series,
                           input string tag);
    bit_valid = 1'b1;
    bit_in    = b;
    #1;
    check({tag, " bit_ready"}, 32'(bit_ready), 1);
    check({tag, " early dc_valid"}, 32'(dc_valid), 0);
    check({tag, " length"}, 32'(length), 32'(exp_len));
    check({tag, " bit_series"}, 32'(bit_series), 32'(exp_series));
    @(posedge clk); #1;
  endtask

  task automatic decode(input int r, input int m, input int hold, input bit do_start,
                        input bit clr_hs, input string tag);
    int          code;
    int          len;
    logic [11:0] exp_dc;
    logic [15:0] ser;
    logic        b;
    huff_code(r, code, len);
    exp_dc = model_dc(model_diff(r, m));
    if (do_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    ser = 16'd0;
    for (int j = 0; j < len; j++) begin
      b      = code[len - 1 - j];
      ser[j] = b;
      drive_bit(b, j + 1, ser, {tag, " code"});
    end
    for (int j = r - 1; j >= 0; j--) begin
      b = m[j];
      drive_bit(b, 0, 16'd0, {tag, " mag"});
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    check({tag, " dc_valid"}, 32'(dc_valid), 1);
    check({tag, " dc_value"}, 32'(dc_value), 32'(exp_dc));
    check({tag, " out bit_ready"}, 32'(bit_ready), 0);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      @(posedge clk); #1;
      check({tag, " hold dc_valid"}, 32'(dc_valid), 1);
      check({tag, " hold dc_value"}, 32'(dc_value), 32'(exp_dc));
      check({tag, " hold bit_ready"}, 32'(bit_ready), 0);
    end
    start      = 1'b0;
    dc_ready   = 1'b1;
    pred_clear = clr_hs;
    @(posedge clk); #1;
    dc_ready   = 1'b0;
    pred_clear = 1'b0;
    check({tag, " dc_valid drop"}, 32'(dc_valid), 0);
    model_pred = clr_hs ? 0 : int'(exp_dc);
  endtask

  initial begin
    int r;
    int m;
    rst_n      = 1'b0;
    start      = 1'b0;
    pred_clear = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    dc_ready   = 1'b0;

    #2;
    check("reset dc_valid", 32'(dc_valid), 0);
    check("reset dc_value", 32'(dc_value), 0);
    check("reset err", 32'(err), 0);
    check("reset bit_ready", 32'(bit_ready), 0);
    check("reset length", 32'(length), 0);
    check("reset bit_series", 32'(bit_series), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    decode(0, 0, 0, 1'b1, 1'b0, "cat0");
    decode(2, 2, 0, 1'b1, 1'b0, "pos2");
    decode(1, 0, 0, 1'b1, 1'b0, "neg1");
    decode(3, 2, 5, 1'b1, 1'b0, "hold5");
    decode(4, 9, 0, 1'b1, 1'b0, "after hold");

    pred_clear = 1'b1;
    @(posedge clk); #1;
    pred_clear = 1'b0;
    model_pred = 0;
    decode(11, 2047, 0, 1'b1, 1'b0, "max");
    decode(1, 1, 0, 1'b1, 1'b0, "wrap");

    // Nine ones never match the table.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 9; j++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      #1;
      check("err before 9th", 32'(err), 0);
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    check("err set", 32'(err), 1);
    check("err bit_ready", 32'(bit_ready), 0);
    check("err dc_valid", 32'(dc_valid), 0);
    @(posedge clk); #1;
    check("err held", 32'(err), 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err cleared", 32'(err), 0);
    check("err restart bit_ready", 32'(bit_ready), 1);
    decode(0, 0, 0, 1'b0, 1'b0, "after err");

    for (int it = 0; it < 24; it++) begin
      r = int'($urandom_range(0, 11));
      m = (r == 0) ? 0 : int'($urandom_range(0, (1 << r) - 1));
      decode(r, m, int'($urandom_range(0, 3)), 1'b1, ($urandom_range(0, 4) == 0), "rand");
    end

    decode(4, 12, 0, 1'b1, 1'b0, "pre reset");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_bit(1'b1, 1, 16'h0001, "abort code");
    drive_bit(1'b1, 2, 16'h0003, "abort code");
    drive_bit(1'b0, 3, 16'h0003, "abort code");
    drive_bit(1'b1, 0, 16'h0000, "abort mag");
    drive_bit(1'b0, 0, 16'h0000, "abort mag");
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort dc_valid", 32'(dc_valid), 0);
    check("abort dc_value", 32'(dc_value), 0);
    check("abort bit_ready", 32'(bit_ready), 0);
    check("abort err", 32'(err), 0);
    check("abort length", 32'(length), 0);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_pred = 0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort no dc_valid", 32'(dc_valid), 0);
    end
    decode(3, 2, 0, 1'b1, 1'b0, "post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
